// File: rtl/wb_cache_assoc.sv
// Write-back, write-allocate, set-associative line cache (1 or 2 ways).
// CPU side and memory side both use valid/ready handshakes; one memory
// request outstanding at most. Dirty victims are written back before reuse.
module wb_cache_assoc #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 1024,
    parameter int SETS   = 64,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [LINE_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic              cpu_resp_hit,
    output logic [LINE_W-1:0] cpu_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_rdata
);

    localparam int OFF   = $clog2(LINE_W / 8);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX - OFF;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } state_t;

    state_t state_q, state_d;

    // Latched request
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [LINE_W-1:0] req_wdata_q, req_wdata_d;

    // Miss bookkeeping and registered outputs
    logic              victim_q, victim_d;
    logic              hit_q, hit_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    // Storage: status bits are reset, tag/data arrays are not
    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   dirty_q [WAYS];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] data_q  [WAYS][SETS];

    // Array write controls produced by the FSM
    logic              arr_we;
    logic              arr_way;
    logic              arr_dirty;
    logic [LINE_W-1:0] arr_data;
    logic              clr_dirty;
    logic              lru_we;
    logic              lru_val;

    logic [IDX-1:0]    idx;
    logic [TAG_W-1:0]  tag;
    logic              lk_hit;
    logic              lk_way;
    logic              lk_victim;

    assign idx = req_addr_q[IDX+OFF-1:OFF];
    assign tag = req_addr_q[ADDR_W-1:IDX+OFF];

    assign cpu_req_ready  = rst && (state_q == IDLE);
    assign cpu_resp_valid = (state_q == RESP);
    assign cpu_resp_hit   = hit_q;
    assign cpu_resp_rdata = rdata_q;
    assign mem_req_valid  = (state_q == WB_REQ) || (state_q == FILL_REQ);
    assign mem_req_we     = mem_we_q;
    assign mem_req_addr   = mem_addr_q;
    assign mem_req_wdata  = mem_wdata_q;

    // Tag compare across the set and victim choice (first invalid, else LRU)
    always_comb begin
        lk_hit    = 1'b0;
        lk_way    = 1'b0;
        lk_victim = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                lk_hit = 1'b1;
                lk_way = w[0];
            end
        end
        if (!valid_q[0][idx]) begin
            lk_victim = 1'b0;
        end else if (WAYS > 1) begin
            if (!valid_q[WAYS-1][idx]) begin
                lk_victim = 1'b1;
            end else begin
                lk_victim = lru_q[idx];
            end
        end
    end

    // Next-state, datapath and array-write decisions
    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        victim_d    = victim_q;
        hit_d       = hit_q;
        rdata_d     = rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        arr_we      = 1'b0;
        arr_way     = 1'b0;
        arr_dirty   = 1'b0;
        arr_data    = '0;
        clr_dirty   = 1'b0;
        lru_we      = 1'b0;
        lru_val     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_valid && cpu_req_ready) begin
                    req_we_d    = cpu_req_we;
                    req_addr_d  = cpu_req_addr;
                    req_wdata_d = cpu_req_wdata;
                    state_d     = LOOKUP;
                end
            end

            LOOKUP: begin
                if (lk_hit) begin
                    hit_d   = 1'b1;
                    lru_we  = (WAYS > 1);
                    lru_val = ~lk_way;
                    if (req_we_q) begin
                        arr_we    = 1'b1;
                        arr_way   = lk_way;
                        arr_dirty = 1'b1;
                        arr_data  = req_wdata_q;
                        rdata_d   = req_wdata_q;
                    end else begin
                        rdata_d = data_q[lk_way][idx];
                    end
                    state_d = RESP;
                end else begin
                    hit_d    = 1'b0;
                    victim_d = lk_victim;
                    if (valid_q[lk_victim][idx] && dirty_q[lk_victim][idx]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[lk_victim][idx], idx, {OFF{1'b0}}};
                        mem_wdata_d = data_q[lk_victim][idx];
                        state_d     = WB_REQ;
                    end else if (req_we_q) begin
                        // Full-line write: allocate without a refill read
                        arr_we    = 1'b1;
                        arr_way   = lk_victim;
                        arr_dirty = 1'b1;
                        arr_data  = req_wdata_q;
                        rdata_d   = req_wdata_q;
                        lru_we    = (WAYS > 1);
                        lru_val   = ~lk_victim;
                        state_d   = RESP;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = {tag, idx, {OFF{1'b0}}};
                        state_d    = FILL_REQ;
                    end
                end
            end

            WB_REQ: begin
                if (mem_req_ready) begin
                    state_d = WB_WAIT;
                end
            end

            WB_WAIT: begin
                if (mem_resp_valid) begin
                    if (req_we_q) begin
                        // Install overwrites the victim, so its dirty bit is simply re-set
                        arr_we    = 1'b1;
                        arr_way   = victim_q;
                        arr_dirty = 1'b1;
                        arr_data  = req_wdata_q;
                        rdata_d   = req_wdata_q;
                        lru_we    = (WAYS > 1);
                        lru_val   = ~victim_q;
                        state_d   = RESP;
                    end else begin
                        clr_dirty  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {tag, idx, {OFF{1'b0}}};
                        state_d    = FILL_REQ;
                    end
                end
            end

            FILL_REQ: begin
                if (mem_req_ready) begin
                    state_d = FILL_WAIT;
                end
            end

            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    arr_we    = 1'b1;
                    arr_way   = victim_q;
                    arr_dirty = 1'b0;
                    arr_data  = mem_resp_rdata;
                    rdata_d   = mem_resp_rdata;
                    lru_we    = (WAYS > 1);
                    lru_val   = ~victim_q;
                    state_d   = RESP;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= 1'b0;
            hit_q       <= 1'b0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            victim_q    <= victim_d;
            hit_q       <= hit_d;
            rdata_q     <= rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Valid/dirty/LRU status bits, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (arr_we) begin
                valid_q[arr_way][idx] <= 1'b1;
                dirty_q[arr_way][idx] <= arr_dirty;
            end
            if (clr_dirty) begin
                dirty_q[victim_q][idx] <= 1'b0;
            end
            if (lru_we) begin
                lru_q[idx] <= lru_val;
            end
        end
    end

    // Tag and line storage, not reset
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_q[arr_way][idx]  <= tag;
            data_q[arr_way][idx] <= arr_data;
        end
    end

endmodule

// File: tb/tb_wb_cache_assoc.sv
// Scoreboard bench for wb_cache_assoc: a 2-way instance and a 1-way instance
// share stimulus through a select, served by one memory model.
module tb_wb_cache_assoc;

    localparam int AW = 32;
    localparam int LW = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          sel       = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [LW-1:0] req_wdata = '0;
    logic          mem_ready  = 1'b1;
    logic          mem_rvalid = 1'b0;
    logic [LW-1:0] mem_rdata  = '0;

    logic          v0, v1;
    logic          d0_ready, d0_rv, d0_hit, d0_mv, d0_mwe;
    logic [LW-1:0] d0_rdata, d0_mwdata;
    logic [AW-1:0] d0_maddr;
    logic          d1_ready, d1_rv, d1_hit, d1_mv, d1_mwe;
    logic [LW-1:0] d1_rdata, d1_mwdata;
    logic [AW-1:0] d1_maddr;

    logic          m_cpu_ready, m_resp_valid, m_resp_hit, m_mem_valid, m_mem_we;
    logic [LW-1:0] m_resp_rdata, m_mem_wdata;
    logic [AW-1:0] m_mem_addr;

    assign v0 = req_valid & ~sel;
    assign v1 = req_valid & sel;
    assign m_cpu_ready  = sel ? d1_ready  : d0_ready;
    assign m_resp_valid = sel ? d1_rv     : d0_rv;
    assign m_resp_hit   = sel ? d1_hit    : d0_hit;
    assign m_resp_rdata = sel ? d1_rdata  : d0_rdata;
    assign m_mem_valid  = sel ? d1_mv     : d0_mv;
    assign m_mem_we     = sel ? d1_mwe    : d0_mwe;
    assign m_mem_addr   = sel ? d1_maddr  : d0_maddr;
    assign m_mem_wdata  = sel ? d1_mwdata : d0_mwdata;

    wb_cache_assoc #(.ADDR_W(AW), .LINE_W(LW), .SETS(64), .WAYS(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(v0), .cpu_req_ready(d0_ready), .cpu_req_we(req_we),
        .cpu_req_addr(req_addr), .cpu_req_wdata(req_wdata),
        .cpu_resp_valid(d0_rv), .cpu_resp_hit(d0_hit), .cpu_resp_rdata(d0_rdata),
        .mem_req_valid(d0_mv), .mem_req_ready(mem_ready), .mem_req_we(d0_mwe),
        .mem_req_addr(d0_maddr), .mem_req_wdata(d0_mwdata),
        .mem_resp_valid(mem_rvalid), .mem_resp_rdata(mem_rdata)
    );

    wb_cache_assoc #(.ADDR_W(AW), .LINE_W(LW), .SETS(64), .WAYS(1)) dut_dm (
        .clk(clk), .rst(rst),
        .cpu_req_valid(v1), .cpu_req_ready(d1_ready), .cpu_req_we(req_we),
        .cpu_req_addr(req_addr), .cpu_req_wdata(req_wdata),
        .cpu_resp_valid(d1_rv), .cpu_resp_hit(d1_hit), .cpu_resp_rdata(d1_rdata),
        .mem_req_valid(d1_mv), .mem_req_ready(mem_ready), .mem_req_we(d1_mwe),
        .mem_req_addr(d1_maddr), .mem_req_wdata(d1_mwdata),
        .mem_resp_valid(mem_rvalid), .mem_resp_rdata(mem_rdata)
    );

    typedef struct {
        logic          hit;
        logic [LW-1:0] rdata;
        int            lat;
    } resp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } mem_t;

    resp_t exp_q[$];
    mem_t  exp_mem_q[$];
    mem_t  obs_mem_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    busy     = 1'b0;
    int    cnt      = 0;
    logic [AW-1:0] pend_addr = '0;

    function automatic logic [LW-1:0] fill_pat(input logic [AW-1:0] a);
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = a ^ (32'h5A00_0000 + i);
        return r;
    endfunction

    function automatic logic [LW-1:0] mk_line(input logic [31:0] seed);
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = seed + i * 32'h0101_0003;
        return r;
    endfunction

    // Memory model: accepts when ready, answers 3 cycles after acceptance
    initial begin : mem_model
        mem_t m;
        bit   hs;
        forever begin
            @(posedge clk);
            hs      = m_mem_valid && mem_ready;
            m.we    = m_mem_we;
            m.addr  = m_mem_addr;
            m.wdata = m_mem_wdata;
            #1;
            if (mem_rvalid) mem_rvalid = 1'b0;
            if (busy) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = fill_pat(pend_addr);
                    busy       = 1'b0;
                end
            end
            if (hs && !busy) begin
                obs_mem_q.push_back(m);
                pend_addr = m.addr;
                busy      = 1'b1;
                cnt       = 2;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One CPU transaction; expected response/memory traffic are queued by the caller
    task automatic do_req(input string name, input logic we, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wdata, input logic exp_hit,
                          input logic [LW-1:0] exp_rdata, input int exp_lat, input int stall);
        resp_t e;
        mem_t  em, om;
        int    cyc;
        bit    got;
        exp_q.push_back('{exp_hit, exp_rdata, exp_lat});
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        if (stall > 0) mem_ready = 1'b0;
        cyc = 0;
        while (!m_cpu_ready && cyc < 20) begin @(negedge clk); cyc++; end
        checks++;
        if (m_cpu_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: ready=%b required 1", name, m_cpu_ready);
            req_valid = 1'b0; mem_ready = 1'b1;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        cyc = 0;
        if (stall > 0) begin
            while (!m_mem_valid && cyc < 20) begin @(negedge clk); cyc++; end
            em = exp_mem_q[0];
            for (int i = 0; i < stall; i++) begin
                @(negedge clk); cyc++;
                checks++;
                if (m_mem_valid !== 1'b1 || m_mem_we !== em.we || m_mem_addr !== em.addr ||
                    m_mem_wdata !== em.wdata || m_cpu_ready !== 1'b0 || m_resp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s stall%0d: valid=%b we=%b addr=%h wd_lo=%h ready=%b resp=%b required 1 %b %h %h 0 0",
                             name, i, m_mem_valid, m_mem_we, m_mem_addr, m_mem_wdata[63:0],
                             m_cpu_ready, m_resp_valid, em.we, em.addr, em.wdata[63:0]);
                end
            end
            mem_ready = 1'b1;
        end
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk); cyc++;
            if (m_resp_valid === 1'b1) got = 1'b1;
        end
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s resp: no cpu_resp_valid within %0d cycles, required one", name, cyc);
        end else begin
            if (m_resp_hit !== e.hit) begin
                failures++;
                $display("FAIL %s hit: got %b required %b", name, m_resp_hit, e.hit);
            end
            checks++;
            if (m_resp_rdata !== e.rdata) begin
                failures++;
                $display("FAIL %s rdata: got_lo=%h required_lo=%h", name, m_resp_rdata[63:0], e.rdata[63:0]);
            end
            if (e.lat >= 0) begin
                checks++;
                if (cyc != e.lat) begin
                    failures++;
                    $display("FAIL %s latency: got %0d required %0d", name, cyc, e.lat);
                end
            end
            @(negedge clk);
            checks++;
            if (m_resp_valid !== 1'b0 || m_cpu_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s after_resp: resp_valid=%b ready=%b required 0 1", name, m_resp_valid, m_cpu_ready);
            end
        end
        checks++;
        if (obs_mem_q.size() != exp_mem_q.size()) begin
            failures++;
            $display("FAIL %s mem_count: got %0d required %0d", name, obs_mem_q.size(), exp_mem_q.size());
        end
        while (obs_mem_q.size() > 0 && exp_mem_q.size() > 0) begin
            om = obs_mem_q.pop_front();
            em = exp_mem_q.pop_front();
            checks++;
            if (om.we !== em.we || om.addr !== em.addr || (em.we && om.wdata !== em.wdata)) begin
                failures++;
                $display("FAIL %s mem_req: we=%b addr=%h wd_lo=%h required we=%b addr=%h wd_lo=%h",
                         name, om.we, om.addr, om.wdata[63:0], em.we, em.addr, em.wdata[63:0]);
            end
        end
        obs_mem_q.delete();
        exp_mem_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_cpu_ready !== 1'b0 || m_resp_valid !== 1'b0 || m_resp_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_cpu: ready=%b resp_valid=%b hit=%b required 0 0 0", m_cpu_ready, m_resp_valid, m_resp_hit);
        end
        checks++;
        if (m_resp_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata: got_lo=%h required 0", m_resp_rdata[63:0]);
        end
        checks++;
        if (m_mem_valid !== 1'b0 || m_mem_we !== 1'b0 || m_mem_addr !== '0 || m_mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_mem: valid=%b we=%b addr=%h wd_lo=%h required 0 0 0 0",
                     m_mem_valid, m_mem_we, m_mem_addr, m_mem_wdata[63:0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (m_cpu_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b required 1", m_cpu_ready);
        end
    endtask

    task automatic test_read_miss_hit();
        exp_mem_q.push_back('{1'b0, 32'h0000_0080, '0});
        do_req("rd_miss_80", 1'b0, 32'h0000_0080, '0, 1'b0, fill_pat(32'h0000_0080), 6, 0);
        do_req("rd_hit_80", 1'b0, 32'h0000_0080, '0, 1'b1, fill_pat(32'h0000_0080), 2, 0);
    endtask

    task automatic test_write_alloc();
        logic [LW-1:0] a;
        a = mk_line(32'hA000_0001);
        do_req("wr_alloc_2080", 1'b1, 32'h0000_2080, a, 1'b0, a, 2, 0);
        do_req("rd_hit_2080", 1'b0, 32'h0000_2080, '0, 1'b1, a, 2, 0);
    endtask

    task automatic test_writeback();
        logic [LW-1:0] a, b;
        a = mk_line(32'hA000_0001);
        b = mk_line(32'hB000_0002);
        // touching 0x80 makes the dirty 0x2080 line the LRU victim
        do_req("rd_hit_80_lru", 1'b0, 32'h0000_0080, '0, 1'b1, fill_pat(32'h0000_0080), 2, 0);
        exp_mem_q.push_back('{1'b1, 32'h0000_2080, a});
        do_req("wr_dirty_4080", 1'b1, 32'h0000_4080, b, 1'b0, b, 6, 0);
        exp_mem_q.push_back('{1'b0, 32'h0000_2080, '0});
        do_req("rd_refill_2080", 1'b0, 32'h0000_2080, '0, 1'b0, fill_pat(32'h0000_2080), 6, 0);
        do_req("rd_hit_4080", 1'b0, 32'h0000_4080, '0, 1'b1, b, 2, 0);
    endtask

    task automatic test_stall();
        logic [LW-1:0] c, d, e;
        c = mk_line(32'hC000_0003);
        d = mk_line(32'hD000_0004);
        e = mk_line(32'hE000_0005);
        do_req("wr_alloc_100", 1'b1, 32'h0000_0100, c, 1'b0, c, 2, 0);
        do_req("wr_alloc_2100", 1'b1, 32'h0000_2100, d, 1'b0, d, 2, 0);
        exp_mem_q.push_back('{1'b1, 32'h0000_0100, c});
        do_req("wr_stall_4100", 1'b1, 32'h0000_4100, e, 1'b0, e, -1, 5);
        // dirty 0x2100 evicted, then refill: writeback and fill both in one request
        exp_mem_q.push_back('{1'b1, 32'h0000_2100, d});
        exp_mem_q.push_back('{1'b0, 32'h0000_0100, '0});
        do_req("rd_wb_fill_100", 1'b0, 32'h0000_0100, '0, 1'b0, fill_pat(32'h0000_0100), 10, 0);
    endtask

    task automatic test_reset_abort();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0180; req_wdata = '0;
        n = 0;
        while (!m_cpu_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!busy && n < 20) begin @(posedge clk); #2; n++; end
        checks++;
        if (!busy) begin
            failures++;
            $display("FAIL abort_fill_req: no fill request seen within %0d cycles", n);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_cpu_ready !== 1'b0 || m_resp_valid !== 1'b0 || m_mem_valid !== 1'b0 ||
            m_mem_addr !== '0 || m_mem_we !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_reset: ready=%b resp=%b mvalid=%b maddr=%h mwe=%b required 0 0 0 0 0",
                     m_cpu_ready, m_resp_valid, m_mem_valid, m_mem_addr, m_mem_we);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (m_resp_valid !== 1'b0 || m_mem_valid !== 1'b0 || m_cpu_ready !== 1'b1) begin
                failures++;
                $display("FAIL abort_late_resp%0d: resp=%b mvalid=%b ready=%b required 0 0 1",
                         i, m_resp_valid, m_mem_valid, m_cpu_ready);
            end
        end
        obs_mem_q.delete();
        exp_mem_q.delete();
        exp_mem_q.push_back('{1'b0, 32'h0000_0180, '0});
        do_req("rd_after_abort_180", 1'b0, 32'h0000_0180, '0, 1'b0, fill_pat(32'h0000_0180), 6, 0);
        exp_mem_q.push_back('{1'b0, 32'h0000_0080, '0});
        do_req("rd_after_abort_80", 1'b0, 32'h0000_0080, '0, 1'b0, fill_pat(32'h0000_0080), 6, 0);
    endtask

    task automatic test_direct_mapped();
        logic [AW-1:0] a;
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 1) ? 32'h0000_2080 : 32'h0000_0080;
            exp_mem_q.push_back('{1'b0, a, '0});
            do_req($sformatf("dm_rd%0d", i), 1'b0, a, '0, 1'b0, fill_pat(a), 6, 0);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_write_alloc();
        test_writeback();
        test_stall();
        test_reset_abort();
        test_direct_mapped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_cache_assoc.md
# wb_cache_assoc

Parametrised write-back, write-allocate, set-associative line cache. It sits between the CPU datapath's line-wide load/store port and the slow main-memory model. Requests and memory traffic both use valid/ready handshakes instead of fixed cycle counters. Dirty victims are written back before replacement, and full-line write misses allocate without a refill read.

## Interface
- ADDR_W, 32, byte-address width
- LINE_W, 1024, line width in bits (power of two, ≥ 64); OFF = log2(LINE_W/8)
- SETS, 64, number of sets (power of two); IDX = log2(SETS); TAG_W = ADDR_W − IDX − OFF
- WAYS, 2, associativity; legal values 1 or 2

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req_valid  in  1  request present
- cpu_req_ready  out  1  cache accepts request (high only in IDLE)
- cpu_req_we  in  1  1 = full-line write, 0 = line read
- cpu_req_addr  in  ADDR_W  byte address; offset bits ignored
- cpu_req_wdata  in  LINE_W  write line
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_resp_hit  out  1  1 = request hit, valid with cpu_resp_valid
- cpu_resp_rdata  out  LINE_W  line contents after the operation
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = writeback, 0 = fill
- mem_req_addr  out  ADDR_W  line-aligned address (offset bits 0)
- mem_req_wdata  out  LINE_W  victim line for writeback
- mem_resp_valid  in  1  memory completion (write done / read data valid)
- mem_resp_rdata  in  LINE_W  fill data

## Operation
- Address split: tag = addr[ADDR_W−1 : IDX+OFF], index = addr[IDX+OFF−1 : OFF].
- Per set/way storage: valid, dirty, tag, data. Each set has one LRU bit (unused when WAYS=1).
- FSM states are IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT and RESP.
- IDLE: cpu_req_ready=1. A handshake (valid && ready) latches we, addr and wdata, then the FSM goes to LOOKUP.
- LOOKUP: compare the tag against all valid ways of the set.
  - Read hit: rdata = the way's line. The LRU bit points to the other way. Go to RESP with hit=1.
  - Write hit: overwrite the line and set dirty=1. Update LRU. rdata = wdata. Go to RESP with hit=1.
  - Miss, victim selection: the first invalid way (way 0 first); otherwise the way named by LRU.
  - Miss, victim valid and dirty: go to WB_REQ.
  - Miss, victim clean: a read goes to FILL_REQ. A write installs wdata with dirty=1, updates tag/valid/LRU, and goes to RESP with hit=0.
- WB_REQ: mem_req_valid=1, we=1, address = {victim tag, index, 0}, wdata = victim line. All fields are held stable until mem_req_ready, then the FSM goes to WB_WAIT.
- WB_WAIT: wait for mem_resp_valid, then clear the victim's dirty bit.
  - Read: go to FILL_REQ.
  - Write: install as on a clean write miss.
- FILL_REQ: mem_req_valid=1, we=0, address = the line-aligned request address. Held until mem_req_ready, then go to FILL_WAIT.
- FILL_WAIT: on mem_resp_valid, install mem_resp_rdata with valid=1 and dirty=0. Update tag and LRU. rdata = the fill data. Go to RESP with hit=0.
- RESP: cpu_resp_valid=1 for exactly one cycle, then go to IDLE.
- At most one memory request is outstanding. mem_resp_valid outside WB_WAIT/FILL_WAIT is ignored.
- With WAYS=1 the block behaves as direct-mapped and LRU is ignored.

## Timing
- Reset (rst=0, asynchronous): all valid, dirty and LRU bits are cleared and the state is IDLE.
  - Output reset values: cpu_req_ready=0 while reset is asserted, then 1 in IDLE. cpu_resp_valid=0, cpu_resp_hit=0, cpu_resp_rdata=0. mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0.
  - Data arrays are not cleared.
- Reset mid-transaction aborts it. Any outstanding memory request is dropped and dirty contents are lost. Later memory responses are ignored.
- Hit: acceptance at edge E0; LOOKUP during E0→E1; cpu_resp_valid high during E1→E2.
- Clean miss: acceptance, then one LOOKUP cycle, the FILL_REQ cycle(s) and the FILL_WAIT cycles, then RESP in the cycle after the mem_resp_valid edge.
- Dirty miss adds the WB_REQ and WB_WAIT phases before the fill.
- The earliest next request is accepted in the cycle after RESP.
- mem_req_valid is never deasserted before mem_req_ready is sampled high.
- Back-to-back requests to the same set see state already updated by the previous request.

## Test plan
Defaults throughout; the memory model has ready=1 and answers 3 cycles after acceptance.
- Reset, then read 0x0000_0080 → one fill request at address 0x80. Response hit=0 with rdata = model data; the same read again → hit=1 with resp 2 cycles after acceptance.
- Write 0x0000_2080 with data A (set 1, way 1 free) → hit=0 with no memory traffic. Read it back → hit=1, rdata=A.
- Write 0x0000_4080 with data B (third tag in set 1; LRU victim = the dirty 0x2080 line) → writeback to 0x2080 with data A, no fill, hit=0. Read 0x2080 → fill request, hit=0.
- Hold mem_req_ready=0 for 5 cycles during a writeback → mem_req_valid, addr and wdata stay stable, cpu_req_ready stays 0, and no resp is produced until completion.
- Pull rst low during FILL_WAIT, then release it and inject a late mem_resp_valid → it is ignored. A read of the same address misses (valid was cleared).
- With WAYS=1, alternate reads of 0x0080 and 0x2080 → every access misses with hit=0 and no writebacks.
